// File: rtl/gfx_pkg.sv
// Shared graphics types: blit command layout, blitter FSM states and
// framebuffer geometry defaults used by both the blitter and the drawer.
package gfx_pkg;

    localparam logic [19:0] BUFFER_START_DEF = 20'h00000;
    localparam int          FB_WIDTH_DEF     = 320;
    localparam int          FB_HEIGHT_DEF    = 240;
    localparam logic [3:0]  TRANSPARENT_IDX  = 4'h0;

    typedef struct packed {
        logic [19:0] src;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [5:0]  w;
        logic [5:0]  h;
    } blit_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        GRAB,
        LOAD,
        RD_ADDR,
        RD_CAP,
        WR_LOW,
        WR_HIGH,
        ADVANCE,
        HANDOFF,
        WAIT_ACK
    } blit_state_t;

endpackage

// File: rtl/blit_cmd_fifo.sv
// Small synchronous command queue. Pointers carry one wrap bit so full and
// empty are distinguished without a separate counter. A push while full is
// only taken when a pop happens in the same cycle.
module blit_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  blit_cmd_t push_data,
    input  logic      pop,
    output blit_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    blit_cmd_t   mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; the only state that reset needs to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: queues blit commands and, once the drawer opens the SRAM
// window, copies each sprite rectangle into the framebuffer, skipping
// transparent and off-screen pixels, then hands SRAM back to the drawer.
// All SRAM pins are registered and derived from the next state, so each
// state's pin values are present on the bus while that state is current.
module sprite_blitter
    import gfx_pkg::*;
#(
    parameter logic [19:0] BUFFER_START = BUFFER_START_DEF,
    parameter int          FB_WIDTH     = FB_WIDTH_DEF,
    parameter int          FB_HEIGHT    = FB_HEIGHT_DEF,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [3:0]  TRANSPARENT  = TRANSPARENT_IDX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [19:0] cmd_src,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [5:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic        blitter_start,
    output logic        in_control,
    output logic        enable,
    input  logic        acknowledge,
    output logic        ack_back,
    output logic        busy,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    blit_state_t state, state_nxt;

    blit_cmd_t   push_data, head;
    logic        fifo_full, fifo_empty, pop;

    logic [9:0]  cur_x, x_nxt;
    logic [8:0]  cur_y, y_nxt;
    logic [5:0]  cur_w, w_nxt;
    logic [5:0]  cur_h, h_nxt;
    logic [5:0]  row, row_nxt;
    logic [5:0]  col, col_nxt;
    logic [19:0] src_ptr, src_nxt;

    logic        last_col, last_row;
    logic [10:0] px;
    logic [9:0]  py;
    logic [19:0] dst;

    logic        in_control_nxt, enable_nxt, ack_back_nxt;
    logic [19:0] addr_nxt;
    logic [15:0] dq_out_nxt;
    logic        dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt;

    // Only the palette nibble of each sprite word carries pixel data.
    logic        unused_dq_hi;
    assign unused_dq_hi = ^sram_dq_in[15:4];

    // Constant-width row offset built from the set bits of FB_WIDTH.
    function automatic logic [19:0] row_base(input logic [9:0] y);
        logic [19:0] acc;
        acc = '0;
        for (int b = 0; b < 11; b++) begin
            if (FB_WIDTH[b]) acc = acc + (20'(y) << b);
        end
        return acc;
    endfunction

    // True when the sprite pixel at (col,row) lands outside the framebuffer.
    function automatic logic is_clipped(input logic [9:0] x, input logic [8:0] y,
                                        input logic [5:0] c, input logic [5:0] r);
        logic [10:0] tx;
        logic [9:0]  ty;
        tx = {1'b0, x} + {5'b0, c};
        ty = {1'b0, y} + {4'b0, r};
        return (32'(tx) >= FB_WIDTH) || (32'(ty) >= FB_HEIGHT);
    endfunction

    assign push_data = '{src: cmd_src, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    blit_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign last_col = (col == cur_w - 6'd1);
    assign last_row = (row == cur_h - 6'd1);
    assign px       = {1'b0, cur_x} + {5'b0, col};
    assign py       = {1'b0, cur_y} + {4'b0, row};
    assign dst      = BUFFER_START + row_base(py) + 20'(px);

    // Next-state, counter updates and next SRAM pin values.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        x_nxt     = cur_x;
        y_nxt     = cur_y;
        w_nxt     = cur_w;
        h_nxt     = cur_h;
        row_nxt   = row;
        col_nxt   = col;
        src_nxt   = src_ptr;

        case (state)
            IDLE:     if (blitter_start) state_nxt = GRAB;
            GRAB:     state_nxt = fifo_empty ? HANDOFF : LOAD;
            LOAD: begin
                pop     = 1'b1;
                x_nxt   = head.x;
                y_nxt   = head.y;
                w_nxt   = head.w;
                h_nxt   = head.h;
                row_nxt = '0;
                col_nxt = '0;
                src_nxt = head.src;
                if (head.w == 6'd0 || head.h == 6'd0)
                    state_nxt = GRAB;
                else if (is_clipped(head.x, head.y, 6'd0, 6'd0))
                    state_nxt = ADVANCE;
                else
                    state_nxt = RD_ADDR;
            end
            RD_ADDR:  state_nxt = RD_CAP;
            RD_CAP:   state_nxt = (sram_dq_in[3:0] == TRANSPARENT) ? ADVANCE : WR_LOW;
            WR_LOW:   state_nxt = WR_HIGH;
            WR_HIGH:  state_nxt = ADVANCE;
            ADVANCE: begin
                src_nxt = src_ptr + 20'd1;
                if (last_col) begin
                    col_nxt = '0;
                    row_nxt = row + 6'd1;
                end else begin
                    col_nxt = col + 6'd1;
                end
                if (last_col && last_row)
                    state_nxt = GRAB;
                else if (is_clipped(cur_x, cur_y, col_nxt, row_nxt))
                    state_nxt = ADVANCE;
                else
                    state_nxt = RD_ADDR;
            end
            HANDOFF:  state_nxt = WAIT_ACK;
            WAIT_ACK: if (acknowledge) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        in_control_nxt = (state_nxt inside {GRAB, LOAD, RD_ADDR, RD_CAP, WR_LOW,
                                            WR_HIGH, ADVANCE, HANDOFF});
        enable_nxt     = (state_nxt == WAIT_ACK);
        ack_back_nxt   = (state == WAIT_ACK) && acknowledge;

        addr_nxt   = sram_addr;
        dq_out_nxt = sram_dq_out;
        dq_oe_nxt  = 1'b0;
        ce_n_nxt   = 1'b1;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        ub_n_nxt   = 1'b1;
        lb_n_nxt   = 1'b1;

        case (state_nxt)
            RD_ADDR, RD_CAP: begin
                addr_nxt = src_nxt;
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                ub_n_nxt = 1'b0;
                lb_n_nxt = 1'b0;
            end
            WR_LOW: begin
                addr_nxt   = dst;
                dq_out_nxt = {12'h000, sram_dq_in[3:0]};
                dq_oe_nxt  = 1'b1;
                ce_n_nxt   = 1'b0;
                we_n_nxt   = 1'b0;
                ub_n_nxt   = 1'b0;
                lb_n_nxt   = 1'b0;
            end
            WR_HIGH: begin
                // we_n rises while address and data stay put for hold time.
                dq_oe_nxt = 1'b1;
                ce_n_nxt  = 1'b0;
                ub_n_nxt  = 1'b0;
                lb_n_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Control state and SRAM pins; reset releases the bus immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_control <= 1'b0;
            enable     <= 1'b0;
            ack_back   <= 1'b0;
            sram_addr  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_control <= in_control_nxt;
            enable     <= enable_nxt;
            ack_back   <= ack_back_nxt;
            sram_addr  <= addr_nxt;
            sram_dq_oe <= dq_oe_nxt;
            sram_ce_n  <= ce_n_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
            sram_ub_n  <= ub_n_nxt;
            sram_lb_n  <= lb_n_nxt;
        end
    end

    // Datapath registers: current command, pixel counters, write data.
    always_ff @(posedge clk) begin
        cur_x       <= x_nxt;
        cur_y       <= y_nxt;
        cur_w       <= w_nxt;
        cur_h       <= h_nxt;
        row         <= row_nxt;
        col         <= col_nxt;
        src_ptr     <= src_nxt;
        sram_dq_out <= dq_out_nxt;
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: behavioural SRAM with one-cycle read data, a
// drawer handshake driven from the stimulus thread, and a write scoreboard
// that a negedge monitor drains whenever the DUT strobes a write.
module tb_sprite_blitter;
    import gfx_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [19:0] cmd_src = '0;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [5:0]  cmd_w = '0;
    logic [5:0]  cmd_h = '0;
    logic        blitter_start = 1'b0;
    logic        in_control, enable, ack_back, busy;
    logic        acknowledge = 1'b0;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src       (cmd_src),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .blitter_start (blitter_start),
        .in_control    (in_control),
        .enable        (enable),
        .acknowledge   (acknowledge),
        .ack_back      (ack_back),
        .busy          (busy),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_oe    (sram_dq_oe),
        .sram_dq_in    (sram_dq_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_ub_n     (sram_ub_n),
        .sram_lb_n     (sram_lb_n)
    );

    // Sprite storage: unknown addresses return an opaque marker so a stray
    // read turns into an unexpected write.
    logic [15:0] src_mem [logic [19:0]];
    logic [15:0] rd_q = 16'h0000;
    assign sram_dq_in = rd_q;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_oe_n)
            rd_q <= src_mem.exists(sram_addr) ? src_mem[sram_addr] : 16'hDEAD;
    end

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_strobe = 0;

    // Monitor: bus protocol every cycle, scoreboard pop on every write.
    always @(negedge clk) begin
        n_checks++;
        if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n) ||
            (!in_control && (!sram_ce_n || !sram_oe_n || !sram_we_n || sram_dq_oe))) begin
            n_fail++;
            $display("FAIL sram_protocol t=%0t actual ce_n=%b oe_n=%b we_n=%b dq_oe=%b in_control=%b required exclusive strobes owned by blitter",
                     $time, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, in_control);
        end
        if (!sram_ce_n || !sram_oe_n || !sram_we_n) n_strobe++;
        if (!sram_ce_n && !sram_we_n) begin
            n_writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sram_write t=%0t actual addr=%05h data=%04h required no write", $time, sram_addr, sram_dq_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (sram_addr !== mon_e.a || sram_dq_out !== mon_e.d || sram_dq_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sram_write t=%0t actual addr=%05h data=%04h oe=%b required addr=%05h data=%04h oe=1",
                             $time, sram_addr, sram_dq_out, sram_dq_oe, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [19:0] s, input logic [9:0] x, input logic [8:0] y,
                            input logic [5:0] w, input logic [5:0] h);
        cmd_src = s; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [19:0] a, input logic [15:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic open_window();
        blitter_start = 1'b1;
        tick(1);
        blitter_start = 1'b0;
    endtask

    task automatic wait_enable(input int limit, output int cyc);
        cyc = 0;
        while (enable !== 1'b1 && cyc < limit) begin
            tick(1);
            cyc++;
        end
        n_checks++;
        if (enable !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_timeout actual=%0d cycles required enable within %0d", cyc, limit);
        end
    endtask

    task automatic handshake();
        check("in_control_released", in_control, 0);
        acknowledge = 1'b1;
        tick(1);
        check("ack_back_pulse", ack_back, 1);
        check("enable_dropped", enable, 0);
        acknowledge = 1'b0;
        tick(1);
        check("ack_back_single", ack_back, 0);
    endtask

    int cyc;
    int w0;
    int s0;

    initial begin
        // Reset state
        tick(3);
        check("rst_in_control", in_control, 0);
        check("rst_enable", enable, 0);
        check("rst_ack_back", ack_back, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(2);

        // 2x2 sprite with one transparent pixel at (10,5)
        src_mem[20'h01000] = 16'h0003;
        src_mem[20'h01001] = 16'h0000;
        src_mem[20'h01002] = 16'h0007;
        src_mem[20'h01003] = 16'h0009;
        push_cmd(20'h01000, 10'd10, 9'd5, 6'd2, 6'd2);
        check("busy_queued", busy, 1);
        expect_write(20'h0064A, 16'h0003);
        expect_write(20'h0078A, 16'h0007);
        expect_write(20'h0078B, 16'h0009);
        w0 = n_writes;
        open_window();
        wait_enable(500, cyc);
        handshake();
        check("t1_write_count", n_writes - w0, 3);
        check("t1_busy_done", busy, 0);

        // Clipping: null command, bottom-edge clip, right-edge clip
        src_mem[20'h03000] = 16'h0005;
        src_mem[20'h03001] = 16'h0006;
        src_mem[20'h03002] = 16'h0007;
        src_mem[20'h03010] = 16'h0004;
        src_mem[20'h03011] = 16'h0004;
        push_cmd(20'h03100, 10'd0, 9'd0, 6'd0, 6'd3);
        push_cmd(20'h03010, 10'd0, 9'd239, 6'd1, 6'd2);
        push_cmd(20'h03000, 10'd319, 9'd0, 6'd3, 6'd1);
        expect_write(20'h12AC0, 16'h0004);
        expect_write(20'h0013F, 16'h0005);
        w0 = n_writes;
        open_window();
        wait_enable(500, cyc);
        handshake();
        check("t2_write_count", n_writes - w0, 2);
        check("t2_src_ptr_end", dut.src_ptr, 20'h03003);

        // Empty queue: straight through GRAB and HANDOFF
        s0 = n_strobe;
        open_window();
        wait_enable(20, cyc);
        check("t3_enable_latency", cyc, 2);
        handshake();
        check("t3_no_strobes", n_strobe - s0, 0);

        // Queue overflow: fifth command dropped
        for (int i = 0; i < 5; i++) src_mem[20'h02000 + 20'(i)] = 16'(i + 1);
        for (int i = 0; i < 4; i++) begin
            check("t4_ready_before_push", cmd_ready, 1);
            push_cmd(20'h02000 + 20'(i), 10'(2 * i), 9'd10, 6'd1, 6'd1);
            expect_write(20'h00C80 + 20'(2 * i), 16'(i + 1));
        end
        check("t4_full", cmd_ready, 0);
        push_cmd(20'h02004, 10'd8, 9'd10, 6'd1, 6'd1);
        check("t4_still_full", cmd_ready, 0);
        w0 = n_writes;
        open_window();
        wait_enable(500, cyc);
        handshake();
        check("t4_serviced", n_writes - w0, 4);
        check("t4_drained_ready", cmd_ready, 1);
        check("t4_drained_busy", busy, 0);

        // Reset in the middle of a write
        src_mem[20'h04000] = 16'h000A;
        src_mem[20'h04001] = 16'h000B;
        push_cmd(20'h04000, 10'd50, 9'd50, 6'd1, 6'd1);
        push_cmd(20'h04001, 10'd51, 9'd50, 6'd1, 6'd1);
        expect_write(20'h03EB2, 16'h000A);
        open_window();
        cyc = 0;
        while (sram_we_n !== 1'b0 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check("t5_reached_wr_low", sram_we_n, 0);
        reset = 1'b1;
        tick(1);
        check("t5_we_n", sram_we_n, 1);
        check("t5_dq_oe", sram_dq_oe, 0);
        check("t5_in_control", in_control, 0);
        check("t5_queue_empty", cmd_ready, 1);
        check("t5_idle", busy, 0);
        check("t5_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        reset = 1'b0;
        w0 = n_writes;
        tick(20);
        check("t5_no_more_writes", n_writes - w0, 0);

        // Drawer slow to acknowledge: blitter holds off
        src_mem[20'h05000] = 16'h000C;
        open_window();
        wait_enable(20, cyc);
        push_cmd(20'h05000, 10'd100, 9'd100, 6'd1, 6'd1);
        blitter_start = 1'b1;
        tick(1);
        blitter_start = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 50; i++) begin
            check("t6_enable_held", enable, 1);
            check("t6_in_control_low", in_control, 0);
            tick(1);
        end
        check("t6_no_writes", n_writes - w0, 0);
        handshake();
        check("t6_cmd_kept", busy, 1);
        expect_write(20'h07D64, 16'h000C);
        open_window();
        wait_enable(500, cyc);
        handshake();
        check("t6_serviced", n_writes - w0, 1);
        check("t6_busy_done", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
